// File: rtl/m_store_buffer.sv
// Write-posting store buffer between the EX/MEM register and the data-memory port.
// Loads bypass straight to memory with priority; a load overlapping a pending store stalls until it drains.
module m_store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic             req_we,
  input  logic [2:0]       req_op,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [31:0]      req_pc,
  output logic             req_stall,
  output logic [31:0]      dm_pc,
  output logic [31:0]      dm_addr,
  output logic [31:0]      dm_wd,
  output logic [2:0]       dm_op,
  output logic             dm_wr,
  input  logic             dm_wready,
  output logic [PTR_W:0]   sb_count,
  output logic             sb_empty
);

  logic [31:0]      ent_pc   [DEPTH];
  logic [31:0]      ent_addr [DEPTH];
  logic [31:0]      ent_wd   [DEPTH];
  logic [2:0]       ent_op   [DEPTH];
  logic [DEPTH-1:0] ent_valid;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;

  logic hazard;
  logic full_stall;
  logic load_go;
  logic enq;
  logic deq;

  // Word-granular overlap check against every live entry, independent of access size.
  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_valid[PTR_W'(i)] && (ent_addr[PTR_W'(i)][31:2] == req_addr[31:2]))
        hazard = 1'b1;
    end
    hazard = hazard & req_valid & ~req_we;
  end

  assign full_stall = req_valid & req_we & (count == (PTR_W+1)'(DEPTH));
  assign req_stall  = hazard | full_stall;
  assign load_go    = req_valid & ~req_we & ~hazard;
  assign enq        = req_valid & req_we & ~full_stall;
  assign deq        = dm_wr & dm_wready;

  assign sb_count = count;
  assign sb_empty = (count == '0);

  always_comb begin
    dm_pc   = '0;
    dm_addr = '0;
    dm_wd   = '0;
    dm_op   = '0;
    dm_wr   = 1'b0;
    if (load_go) begin
      dm_pc   = req_pc;
      dm_addr = req_addr;
      dm_op   = req_op;
    end else if (count != '0) begin
      dm_pc   = ent_pc[head];
      dm_addr = ent_addr[head];
      dm_wd   = ent_wd[head];
      dm_op   = ent_op[head];
      dm_wr   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      if (deq) begin
        ent_valid[head] <= 1'b0;
        head            <= head + PTR_W'(1);
      end
      if (enq) begin
        ent_valid[tail] <= 1'b1;
        tail            <= tail + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload needs no reset: an entry is only observed while its valid bit is set.
  always_ff @(posedge clk) begin
    if (enq) begin
      ent_pc[tail]   <= req_pc;
      ent_addr[tail] <= req_addr;
      ent_wd[tail]   <= req_wdata;
      ent_op[tail]   <= req_op;
    end
  end

endmodule

// File: tb/tb_m_store_buffer.sv
// Bench for m_store_buffer: queue-based reference model checked every cycle plus directed literal checks.
module tb_m_store_buffer;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;
  localparam logic [2:0] DM_W = 3'd0, DM_H = 3'd1, DM_B = 3'd2, DM_HU = 3'd3, DM_BU = 3'd4;

  logic clk = 1'b0;
  logic reset;
  logic req_valid, req_we;
  logic [2:0] req_op;
  logic [31:0] req_addr, req_wdata, req_pc;
  logic req_stall;
  logic [31:0] dm_pc, dm_addr, dm_wd;
  logic [2:0] dm_op;
  logic dm_wr, dm_wready;
  logic [PTR_W:0] sb_count;
  logic sb_empty;

  m_store_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .req_stall(req_stall),
    .dm_pc(dm_pc), .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_op(dm_op),
    .dm_wr(dm_wr), .dm_wready(dm_wready),
    .sb_count(sb_count), .sb_empty(sb_empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [2:0]  op;
  } ent_t;

  ent_t        model_q[$];
  logic [31:0] drained[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Reference model: evaluated mid-cycle, then advanced as the coming rising edge will.
  always @(negedge clk) begin
    logic        hz, full, ld, e_wr, e_stall;
    logic [31:0] e_pc, e_addr, e_wd;
    logic [2:0]  e_op;
    if (reset) model_q.delete();
    hz = 1'b0;
    if (req_valid && !req_we)
      foreach (model_q[i]) if (model_q[i].addr[31:2] == req_addr[31:2]) hz = 1'b1;
    full    = req_valid && req_we && (model_q.size() == DEPTH);
    e_stall = hz || full;
    ld      = req_valid && !req_we && !hz;
    e_pc = 0; e_addr = 0; e_wd = 0; e_op = 0; e_wr = 1'b0;
    if (ld) begin
      e_pc = req_pc; e_addr = req_addr; e_op = req_op;
    end else if (model_q.size() > 0) begin
      e_pc = model_q[0].pc; e_addr = model_q[0].addr; e_wd = model_q[0].wd;
      e_op = model_q[0].op; e_wr = 1'b1;
    end
    chk("stall", 32'(req_stall), 32'(e_stall));
    chk("dm_wr", 32'(dm_wr), 32'(e_wr));
    chk("dm_pc", dm_pc, e_pc);
    chk("dm_addr", dm_addr, e_addr);
    chk("dm_wd", dm_wd, e_wd);
    chk("dm_op", 32'(dm_op), 32'(e_op));
    chk("sb_count", 32'(sb_count), model_q.size());
    chk("sb_empty", 32'(sb_empty), 32'(model_q.size() == 0));
    if (!reset) begin
      if (e_wr && dm_wready) begin
        drained.push_back(model_q[0].addr);
        void'(model_q.pop_front());
      end
      if (req_valid && req_we && !full)
        model_q.push_back('{pc: req_pc, addr: req_addr, wd: req_wdata, op: req_op});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0; req_we = 1'b0; req_op = DM_W;
    req_addr = '0; req_wdata = '0; req_pc = '0;
  endtask

  task automatic store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d, input logic [31:0] pc);
    req_valid = 1'b1; req_we = 1'b1; req_op = op; req_addr = a; req_wdata = d; req_pc = pc;
  endtask

  task automatic load(input logic [2:0] op, input logic [31:0] a, input logic [31:0] pc);
    req_valid = 1'b1; req_we = 1'b0; req_op = op; req_addr = a; req_wdata = '0; req_pc = pc;
  endtask

  task automatic drain_all(input string name);
    int budget;
    idle();
    dm_wready = 1'b1;
    budget = 40;
    while (!sb_empty && budget > 0) begin
      tick();
      budget--;
    end
    chk({name, "_drain_timeout"}, 32'(sb_empty), 32'd1);
  endtask

  logic [31:0] exp_order[$];

  initial begin
    reset = 1'b1; dm_wready = 1'b1;
    idle();
    #3;
    chk("rst_count", 32'(sb_count), 32'd0);
    chk("rst_empty", 32'(sb_empty), 32'd1);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Single store drains on the next cycle
    store(DM_W, 32'h10, 32'h12345678, 32'h3000);
    tick();
    idle();
    #2;
    chk("t1_count1", 32'(sb_count), 32'd1);
    chk("t1_wr1", 32'(dm_wr), 32'd1);
    chk("t1_addr", dm_addr, 32'h10);
    chk("t1_wd", dm_wd, 32'h12345678);
    chk("t1_pc", dm_pc, 32'h3000);
    tick();
    chk("t1_count0", 32'(sb_count), 32'd0);
    chk("t1_wr0", 32'(dm_wr), 32'd0);

    // Fill, full stall, drain order
    drained.delete();
    dm_wready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      store(DM_W, 32'h100 + 32'(4 * k), 32'hA000 + 32'(k), 32'h4000 + 32'(4 * k));
      tick();
    end
    store(DM_W, 32'h110, 32'hA004, 32'h4010);
    #2;
    chk("t2_count4", 32'(sb_count), 32'd4);
    chk("t2_stall", 32'(req_stall), 32'd1);
    tick();
    chk("t2_held", 32'(sb_count), 32'd4);
    dm_wready = 1'b1;
    tick();
    chk("t2_count3", 32'(sb_count), 32'd3);
    chk("t2_unstall", 32'(req_stall), 32'd0);
    tick();
    drain_all("t2");
    exp_order = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110};
    chk("t2_ndrained", drained.size(), 5);
    foreach (exp_order[i]) if (i < drained.size()) chk("t2_order", drained[i], exp_order[i]);

    // Load hazard against a byte store in the same word
    dm_wready = 1'b0;
    store(DM_B, 32'h203, 32'hAB, 32'h5000);
    tick();
    load(DM_W, 32'h200, 32'h5004);
    #2;
    chk("t3_stall", 32'(req_stall), 32'd1);
    chk("t3_wr", 32'(dm_wr), 32'd1);
    chk("t3_addr", dm_addr, 32'h203);
    tick();
    dm_wready = 1'b1;
    tick();
    chk("t3_stall0", 32'(req_stall), 32'd0);
    chk("t3_addr2", dm_addr, 32'h200);
    chk("t3_wr0", 32'(dm_wr), 32'd0);
    idle();
    tick();

    // Non-overlapping load takes the port, no drain
    dm_wready = 1'b0;
    store(DM_W, 32'h40, 32'h55, 32'h6000);
    tick();
    dm_wready = 1'b1;
    load(DM_W, 32'h80, 32'h6004);
    #2;
    chk("t4_stall", 32'(req_stall), 32'd0);
    chk("t4_addr", dm_addr, 32'h80);
    chk("t4_wr", 32'(dm_wr), 32'd0);
    tick();
    chk("t4_count", 32'(sb_count), 32'd1);
    drain_all("t4");

    // Asynchronous reset mid-cycle discards pending stores
    dm_wready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      store(DM_H, 32'h300 + 32'(4 * k), 32'h77 + 32'(k), 32'h7000);
      tick();
    end
    idle();
    #2;
    chk("t5_pre", 32'(sb_count), 32'd3);
    reset = 1'b1;
    #1;
    chk("t5_count", 32'(sb_count), 32'd0);
    chk("t5_empty", 32'(sb_empty), 32'd1);
    chk("t5_wr", 32'(dm_wr), 32'd0);
    tick();
    reset = 1'b0;
    dm_wready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #2;
      chk("t5_nowr", 32'(dm_wr), 32'd0);
      tick();
    end

    // Pointer wrap with toggling ready
    drained.delete();
    exp_order.delete();
    dm_wready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      int budget;
      store(DM_W, 32'h800 + 32'(4 * k), 32'hC0DE0000 + 32'(k), 32'h8000 + 32'(4 * k));
      exp_order.push_back(32'h800 + 32'(4 * k));
      budget = 20;
      #2;
      while (req_stall && budget > 0) begin
        tick();
        dm_wready = ~dm_wready;
        #2;
        budget--;
      end
      chk("t6_stall_timeout", 32'(req_stall), 32'd0);
      tick();
      dm_wready = ~dm_wready;
    end
    drain_all("t6");
    chk("t6_ndrained", drained.size(), 10);
    foreach (exp_order[i]) if (i < drained.size()) chk("t6_order", drained[i], exp_order[i]);

    // Randomized traffic; stalled requests are re-presented unchanged
    idle();
    for (int c = 0; c < 3000; c++) begin
      if (!(req_valid && req_stall)) begin
        if ($urandom_range(0, 3) != 0) begin
          logic [31:0] a;
          a = 32'h100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
          if ($urandom_range(0, 1) == 1) store(3'($urandom_range(0, 4)), a, $urandom, $urandom);
          else load(3'($urandom_range(0, 4)), a, $urandom);
        end else idle();
      end
      dm_wready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 299) == 0) begin
        #1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
      end else tick();
    end
    drain_all("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout @%0t", $time);
    $fatal(1);
  end
endmodule
